// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: equal-precision frequency-measurement sequencer; opens the
//   counter gate on a SIG rising edge, holds it GATE_CYCLES, closes it on the
//   next SIG rising edge, then latches Nx/Nb so that f = f_base * Nx / Nb.
// Latency: SIG edge seen 2-3 CLK late (sync + edge detect); DONE rises
//   SETTLE_CYCLES+2 CLK after the closing edge is detected.
// Backpressure: none; START is ignored unless idle, DONE holds until next START.
// Ports:
//   CLK, CLR        base clock, asynchronous active-low reset
//   START           single-cycle measurement request (accepted only when idle)
//   SIG             measured signal, asynchronous to CLK
//   Q, QBASE        signal / base counts read back from the counter block
//   CNT_CLR, CNT_EN active-low counter clear, gate for both counter enables
//   BUSY, DONE      measurement in progress / result valid (level)
//   TIMEOUT         last measurement aborted waiting for a SIG edge
//   NX, NB          latched signal and base counts
module freq_gate_ctrl #(
  parameter int unsigned GATE_CYCLES    = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        START,
  input  logic        SIG,
  input  logic [31:0] Q,
  input  logic [31:0] QBASE,
  output logic        CNT_CLR,
  output logic        CNT_EN,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic [31:0] NX,
  output logic [31:0] NB
);

  localparam logic [31:0] CLEAR_LAST   = 32'd1;
  localparam logic [31:0] GATE_LAST    = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CLEAR, ST_ARM, ST_OPEN, ST_CLOSE,
    ST_SETTLE, ST_LATCH, ST_ABORT, ST_FINISH
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        sig_s1, sig_s2, sig_s3;
  logic        sig_rise;
  logic        cnt_clr_nxt, cnt_en_nxt, busy_nxt, done_nxt, timeout_nxt;
  logic [31:0] nx_nxt, nb_nxt;

  // Two flops resolve metastability, the third delays for edge detect.
  assign sig_rise = sig_s2 & ~sig_s3;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sig_s1 <= 1'b0;
      sig_s2 <= 1'b0;
      sig_s3 <= 1'b0;
    end else begin
      sig_s1 <= SIG;
      sig_s2 <= sig_s1;
      sig_s3 <= sig_s2;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      CNT_CLR <= 1'b1;
      CNT_EN  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      TIMEOUT <= 1'b0;
      NX      <= '0;
      NB      <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      CNT_CLR <= cnt_clr_nxt;
      CNT_EN  <= cnt_en_nxt;
      BUSY    <= busy_nxt;
      DONE    <= done_nxt;
      TIMEOUT <= timeout_nxt;
      NX      <= nx_nxt;
      NB      <= nb_nxt;
    end
  end

  // One counter serves the clear, timeout, gate and settle phases since they
  // never overlap; every state change restarts it at 0 so it cannot wrap.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 32'd1;
    cnt_clr_nxt = CNT_CLR;
    cnt_en_nxt  = CNT_EN;
    busy_nxt    = BUSY;
    done_nxt    = DONE;
    timeout_nxt = TIMEOUT;
    nx_nxt      = NX;
    nb_nxt      = NB;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (START) begin
          state_nxt   = ST_CLEAR;
          cnt_clr_nxt = 1'b0;
          busy_nxt    = 1'b1;
          done_nxt    = 1'b0;
          timeout_nxt = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (cnt == CLEAR_LAST) begin
          state_nxt   = ST_ARM;
          cnt_clr_nxt = 1'b1;
          cnt_nxt     = '0;
        end
      end
      ST_ARM: begin
        if (sig_rise) begin
          state_nxt  = ST_OPEN;
          cnt_en_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_ABORT;
          cnt_nxt   = '0;
        end
      end
      ST_OPEN: begin
        // Edges are ignored here: the preset gate time must elapse first.
        if (cnt == GATE_LAST) begin
          state_nxt = ST_CLOSE;
          cnt_nxt   = '0;
        end
      end
      ST_CLOSE: begin
        if (sig_rise) begin
          state_nxt  = ST_SETTLE;
          cnt_en_nxt = 1'b0;
          cnt_nxt    = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt  = ST_ABORT;
          cnt_en_nxt = 1'b0;
          cnt_nxt    = '0;
        end
      end
      ST_SETTLE: begin
        // Counters are frozen here so Q/QBASE are stable when latched.
        if (cnt == SETTLE_LAST) begin
          state_nxt = ST_LATCH;
          cnt_nxt   = '0;
        end
      end
      ST_LATCH: begin
        nx_nxt    = Q;
        nb_nxt    = QBASE;
        state_nxt = ST_FINISH;
        cnt_nxt   = '0;
      end
      ST_ABORT: begin
        cnt_en_nxt  = 1'b0;
        nx_nxt      = '0;
        nb_nxt      = '0;
        timeout_nxt = 1'b1;
        state_nxt   = ST_FINISH;
        cnt_nxt     = '0;
      end
      ST_FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
`timescale 1ns/1ps
module tb_freq_gate_ctrl;

  localparam int G_A = 1000, T_A = 500, S_A = 4;
  localparam int G_B = 10,   T_B = 64,  S_B = 4;
  localparam int NEVER = 32'h3fffffff;

  logic CLK = 1'b0;
  logic CLR;
  logic SIG = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [31:0] q_a = '0, qb_a = '0, q_b = '0, qb_b = '0;
  logic cnt_clr_a, cnt_en_a, busy_a, done_a, timeout_a;
  logic cnt_clr_b, cnt_en_b, busy_b, done_b, timeout_b;
  logic [31:0] nx_a, nb_a, nx_b, nb_b;

  int cyc = 0;
  int checks = 0, failures = 0;

  // SIG plan: periodic (mode 0) or stuck low (mode 1); after p_stop it holds p_hold.
  int p_mode = 1, p_per = 3, p_ph = 0, p_stop = NEVER;
  bit p_hold = 1'b0;

  typedef struct {
    int          done_cyc;
    bit          tmo;
    logic [31:0] nx;
    logic [31:0] nb;
    int          en_cyc;
  } exp_t;

  exp_t q_exp_a[$];
  exp_t q_exp_b[$];

  freq_gate_ctrl #(.GATE_CYCLES(G_A), .TIMEOUT_CYCLES(T_A), .SETTLE_CYCLES(S_A)) dut_a (
    .CLK(CLK), .CLR(CLR), .START(start_a), .SIG(SIG), .Q(q_a), .QBASE(qb_a),
    .CNT_CLR(cnt_clr_a), .CNT_EN(cnt_en_a), .BUSY(busy_a), .DONE(done_a),
    .TIMEOUT(timeout_a), .NX(nx_a), .NB(nb_a));

  freq_gate_ctrl #(.GATE_CYCLES(G_B), .TIMEOUT_CYCLES(T_B), .SETTLE_CYCLES(S_B)) dut_b (
    .CLK(CLK), .CLR(CLR), .START(start_b), .SIG(SIG), .Q(q_b), .QBASE(qb_b),
    .CNT_CLR(cnt_clr_b), .CNT_EN(cnt_en_b), .BUSY(busy_b), .DONE(done_b),
    .TIMEOUT(timeout_b), .NX(nx_b), .NB(nb_b));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Counter block models: Q counts SIG rises, QBASE counts CLK, both while gated.
  always @(posedge SIG or negedge cnt_clr_a)
    if (!cnt_clr_a) q_a <= '0; else if (cnt_en_a) q_a <= q_a + 32'd1;
  always @(posedge CLK or negedge cnt_clr_a)
    if (!cnt_clr_a) qb_a <= '0; else if (cnt_en_a) qb_a <= qb_a + 32'd1;
  always @(posedge SIG or negedge cnt_clr_b)
    if (!cnt_clr_b) q_b <= '0; else if (cnt_en_b) q_b <= q_b + 32'd1;
  always @(posedge CLK or negedge cnt_clr_b)
    if (!cnt_clr_b) qb_b <= '0; else if (cnt_en_b) qb_b <= qb_b + 32'd1;

  function automatic bit sig_at(int t);
    if (p_mode == 1) return 1'b0;
    if (t >= p_stop) return p_hold;
    return ((t + p_ph) % p_per) < ((p_per + 1) / 2);
  endfunction

  function automatic bit rise_at(int t);
    return sig_at(t) && !sig_at(t - 1);
  endfunction

  // SIG value sampled by clock edge k is set half a cycle before that edge.
  always @(negedge CLK) SIG = sig_at(cyc + 1);

  // Reference: an edge sampled at CLK edge r is acted on at edge r+2. The gate
  // can open on rises r0 in [s+1, s+T] and close on rises r1 in [r0+G+1, r0+G+T].
  function automatic exp_t model(int s, int g, int to, int st);
    exp_t e;
    int r0, r1, n;
    e.tmo = 1'b1; e.nx = '0; e.nb = '0; e.en_cyc = 0;
    r0 = -1;
    for (int r = s + 1; r <= s + to; r++) if (rise_at(r)) begin r0 = r; break; end
    if (r0 < 0) begin
      e.done_cyc = s + to + 4;
      return e;
    end
    r1 = -1;
    for (int r = r0 + g + 1; r <= r0 + g + to; r++) if (rise_at(r)) begin r1 = r; break; end
    if (r1 < 0) begin
      e.en_cyc   = g + to;
      e.done_cyc = r0 + g + to + 4;
      return e;
    end
    n = 0;
    for (int r = r0 + 3; r <= r1 + 2; r++) if (rise_at(r)) n++;
    e.tmo      = 1'b0;
    e.nx       = 32'(n);
    e.nb       = 32'(r1 - r0);
    e.en_cyc   = r1 - r0;
    e.done_cyc = r1 + st + 4;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input int now, input int en_n,
                       input int clr_n, input logic busy, input logic tmo,
                       input logic [31:0] nx, input logic [31:0] nb);
    chk({tag, "_done_cycle"}, 32'(now), 32'(e.done_cyc));
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_timeout"}, 32'(tmo), 32'(e.tmo));
    chk({tag, "_nx"}, nx, e.nx);
    chk({tag, "_nb"}, nb, e.nb);
    chk({tag, "_gate_cycles"}, 32'(en_n), 32'(e.en_cyc));
    chk({tag, "_clear_cycles"}, 32'(clr_n), 32'd2);
  endtask

  task automatic unexpected(input string tag);
    checks++;
    failures++;
    $display("FAIL %s_unexpected_done actual=DONE required=no_result_pending", tag);
  endtask

  int en_a = 0, clr_a = 0, en_b = 0, clr_b = 0;
  logic pd_a = 1'b0, pd_b = 1'b0;

  always @(negedge CLK) begin : mon_a
    exp_t e;
    if (!CLR) begin
      en_a = 0; clr_a = 0; pd_a = 1'b0;
    end else begin
      if (cnt_en_a) en_a++;
      if (!cnt_clr_a) clr_a++;
      if (done_a && !pd_a) begin
        if (q_exp_a.size() == 0) unexpected("a");
        else begin
          e = q_exp_a.pop_front();
          score("a", e, cyc, en_a, clr_a, busy_a, timeout_a, nx_a, nb_a);
        end
        en_a = 0; clr_a = 0;
      end
      pd_a = done_a;
    end
  end

  always @(negedge CLK) begin : mon_b
    exp_t e;
    if (!CLR) begin
      en_b = 0; clr_b = 0; pd_b = 1'b0;
    end else begin
      if (cnt_en_b) en_b++;
      if (!cnt_clr_b) clr_b++;
      if (done_b && !pd_b) begin
        if (q_exp_b.size() == 0) unexpected("b");
        else begin
          e = q_exp_b.pop_front();
          score("b", e, cyc, en_b, clr_b, busy_b, timeout_b, nx_b, nb_b);
        end
        en_b = 0; clr_b = 0;
      end
      pd_b = done_b;
    end
  end

  task automatic set_plan(input int mode, input int per, input int ph, input int stop, input bit hold);
    @(posedge CLK); #1;
    p_mode = mode; p_per = per; p_ph = ph; p_stop = stop; p_hold = hold;
  endtask

  task automatic issue(input int gap);
    int s;
    repeat (gap) @(posedge CLK);
    #1;
    start_a = 1'b1; start_b = 1'b1;
    s = cyc + 1;
    q_exp_a.push_back(model(s, G_A, T_A, S_A));
    q_exp_b.push_back(model(s, G_B, T_B, S_B));
    @(posedge CLK); #1;
    start_a = 1'b0; start_b = 1'b0;
    chk("start_sets_busy", 32'(busy_a), 32'd1);
    chk("start_clears_done", 32'(done_a), 32'd0);
    chk("start_clears_timeout", 32'(timeout_a), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q_exp_a.size() != 0 || q_exp_b.size() != 0) && n < budget) begin
      @(posedge CLK);
      n++;
    end
    #1;
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL wait_done actual=no_DONE_after_%0d_cycles required=DONE", budget);
      q_exp_a.delete();
      q_exp_b.delete();
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=simulation_stalled required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    CLR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cnt_clr", 32'(cnt_clr_a), 32'd1);
    chk("rst_cnt_en", 32'(cnt_en_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_timeout", 32'(timeout_a), 32'd0);
    chk("rst_nx", nx_a, 32'd0);
    chk("rst_nb", nb_a, 32'd0);
    @(negedge CLK) CLR = 1'b1;

    // Basic measurement, period 37: the gate spans exactly 28 periods.
    set_plan(0, 37, int'($urandom_range(0, 36)), NEVER, 1'b0);
    issue(6);
    wait_idle(3000);
    chk("basic_nx_28", nx_a, 32'd28);
    chk("basic_nb_28_periods", nb_a, 32'd1036);

    // SIG stuck low: both abort in ARM.
    set_plan(1, 3, 0, NEVER, 1'b0);
    issue(6);
    wait_idle(3000);
    chk("arm_timeout_flag", 32'(timeout_a), 32'd1);

    // SIG stops toggling after the gate opens: long gate aborts in CLOSE.
    set_plan(0, int'($urandom_range(3, 20)), int'($urandom_range(0, 19)), cyc + 70, 1'(($urandom & 1)));
    issue(6);
    wait_idle(3000);

    // START while measuring is ignored by the long-gate instance.
    set_plan(0, int'($urandom_range(3, 60)), int'($urandom_range(0, 59)), NEVER, 1'b0);
    issue(6);
    repeat (200) @(posedge CLK);
    #1;
    start_a = 1'b1;
    @(posedge CLK); #1;
    start_a = 1'b0;
    wait_idle(3000);

    // Reset in the middle of the gate.
    set_plan(0, int'($urandom_range(3, 60)), int'($urandom_range(0, 59)), NEVER, 1'b0);
    issue(6);
    repeat (300) @(posedge CLK);
    #3;
    chk("gate_open_before_reset", 32'(cnt_en_a), 32'd1);
    CLR = 1'b0;
    #1;
    chk("reset_drops_gate", 32'(cnt_en_a), 32'd0);
    chk("reset_drops_busy", 32'(busy_a), 32'd0);
    chk("reset_clears_cnt_clr", 32'(cnt_clr_a), 32'd1);
    q_exp_a.delete();
    q_exp_b.delete();
    @(negedge CLK);
    @(negedge CLK) CLR = 1'b1;

    // Fast SIG, period 3.
    set_plan(0, 3, int'($urandom_range(0, 2)), NEVER, 1'b0);
    issue(6);
    wait_idle(3000);

    // Randomized measurements.
    for (int i = 0; i < 6; i++) begin
      set_plan(($urandom_range(0, 4) == 0) ? 1 : 0, int'($urandom_range(3, 60)),
               int'($urandom_range(0, 59)), NEVER, 1'b0);
      issue(int'($urandom_range(5, 12)));
      wait_idle(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Equal-precision frequency-measurement sequencer that drives the counter pair's clear and enable inputs and reads back both 32-bit counts.
- Runs on the base clock. Opens a gate aligned to a rising edge of the measured signal, holds it for a preset number of base cycles, then closes it on the next signal rising edge.
- Latches Nx (signal count) and Nb (base count) for the downstream MCU interface, so the measured frequency is f = f_base × Nx / Nb.

Parameters:
- GATE_CYCLES, 50000000, preset gate length in CLK cycles (1 s at 50 MHz); must be ≥ 1.
- TIMEOUT_CYCLES, 100000000, maximum CLK cycles spent waiting for a signal edge in ARM or CLOSE.
- SETTLE_CYCLES, 4, CLK cycles between gate close and count latch; must be ≥ 1.

Ports:
- CLK  in  1  base clock; also the clock for the base counter.
- CLR  in  1  asynchronous active-low reset.
- START  in  1  single-cycle request to begin a measurement; ignored while BUSY=1.
- SIG  in  1  measured signal, asynchronous to CLK.
- Q  in  32  signal-edge count from the counter block.
- QBASE  in  32  base-clock count from the counter block.
- CNT_CLR  out  1  active-low clear to the counter block.
- CNT_EN  out  1  gate; drives both counter enables.
- BUSY  out  1  high from START acceptance until DONE rises.
- DONE  out  1  result valid; level signal, cleared by the next accepted START.
- TIMEOUT  out  1  last measurement aborted; valid when DONE=1.
- NX  out  32  latched signal count.
- NB  out  32  latched base count.

Behaviour:
- Reset (CLR=0, async): state=IDLE, CNT_CLR=1, CNT_EN=0, BUSY=0, DONE=0, TIMEOUT=0, NX=0, NB=0, synchronizer flops=0, all internal counters=0.
- SIG synchronizer: 2 flops, then a third flop for edge detect. sig_rise = s2 & ~s3, so latency is 2–3 CLK from the SIG edge. Only sig_rise is used.
- Reset mid-operation: all outputs return to reset values immediately. CNT_EN drops asynchronously.
- FSM:
  - IDLE: on START → CLEAR. In the same edge: BUSY=1, DONE=0, TIMEOUT=0. NX/NB hold their old values.
  - CLEAR: CNT_CLR=0 for exactly 2 cycles → ARM.
  - ARM: waits for sig_rise, with timeout counter running.
    - On sig_rise → OPEN. CNT_EN=1 from the next cycle. Gate counter reset to 0.
    - If the timeout counter reaches TIMEOUT_CYCLES-1 with no edge → ABORT.
  - OPEN: CNT_EN=1. Gate counter increments each cycle; when it reaches GATE_CYCLES-1 → CLOSE. sig_rise is ignored in OPEN.
  - CLOSE: CNT_EN stays 1. Timeout counter restarts at entry.
    - On sig_rise → CNT_EN=0 from the next cycle → SETTLE.
    - If timeout expires → ABORT.
  - SETTLE: CNT_EN=0, waits SETTLE_CYCLES → LATCH.
  - LATCH: one cycle. NX←Q, NB←QBASE → FINISH.
  - ABORT: CNT_EN=0, NX←0, NB←0, TIMEOUT←1 → FINISH.
  - FINISH: DONE=1, BUSY=0 → IDLE. DONE holds until the next START.
- START coincident with FINISH→IDLE is ignored; it is accepted only in IDLE.
- Total gate time is GATE_CYCLES + (0 to 1 SIG period) + synchronizer latency. Nx is an exact integer number of SIG periods.
- Internal counters are 32 bits wide and must not wrap: both parameters are below 2^32.
- Q and QBASE are sampled only in LATCH; at that point the counter block is frozen (CNT_EN=0 for ≥ SETTLE_CYCLES).
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic measurement: GATE_CYCLES=1000, SIG period 37 CLK, counter model attached, START pulse → CNT_CLR low for 2 cycles; CNT_EN high for 1000 + (0..37) cycles; DONE=1, TIMEOUT=0; NX=ceil-aligned edge count (28); NB equals the CNT_EN high cycle count; NB/NX ≈ 37 ±1.
- Timeout in ARM: SIG held 0, TIMEOUT_CYCLES=500 → DONE after ~503 cycles, TIMEOUT=1, NX=0, NB=0, CNT_EN never asserted.
- Timeout in CLOSE: SIG toggles until OPEN, then held constant → ABORT; TIMEOUT=1, NX=NB=0, CNT_EN=0.
- Reset mid-gate: assert CLR=0 during OPEN → CNT_EN=0 and BUSY=0 immediately. After release, a fresh START measures correctly.
- START ignored while busy: pulse START during OPEN → no restart; gate length unchanged. A second START after DONE clears DONE and TIMEOUT in the same edge.
- Fast SIG (period 3 CLK), GATE_CYCLES=10 → gate closes within 3 + sync latency after preset; NX=number of SIG rises within the gate; no missed transition into SETTLE.
